conv_seq_ctrl: RTL

Sequencer for the 3x3 convolution datapath (multiplier layer, rotating-select mux layer, nine accumulators). It holds the datapath in reset while no work is pending and releases it for exactly nine back-to-back pixel beats per tile. It captures the nine accumulator results into an output register, reduces them to integer pixels, and hands them downstream over a valid/ready handshake. It sits between the pixel-window fetch logic and the result writer and runs a programmable number of tiles per start.

---
 rtl/conv_seq_ctrl_pkg.sv | 23 ++
 rtl/conv_seq_ctrl_if.sv | 25 ++
 rtl/conv_seq_lane_fmt.sv | 30 +++
 rtl/conv_seq_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/conv_seq_ctrl_pkg.sv
// rtl/conv_seq_ctrl_pkg.sv - shared widths, state encoding and saturation limits for conv_seq_ctrl
// Build option CONV_SEQ_SAT_EN selects 8-bit saturating pixel output in conv_seq_lane_fmt.
package conv_pkg;

   localparam int TAPS   = 9;
   localparam int ACC_W  = 32;
   localparam int FRAC_W = 10;
   localparam int OUT_W  = ACC_W - FRAC_W;
   localparam int BEAT_W = $clog2(TAPS);
   localparam int TILE_W = 16;

   localparam logic [OUT_W-1:0] SAT_MIN = '0;
   localparam logic [OUT_W-1:0] SAT_MAX = OUT_W'(255);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_MAC,
      ST_DRAIN,
      ST_HOLD
   } state_e;

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// rtl/conv_seq_ctrl_if.sv - pixel-in, datapath and result-out handshake bundle for conv_seq_ctrl
// master is the sequencer side; slave is the fetch/datapath/writer side.
interface conv_seq_ctrl_if
   import conv_pkg::*;
   ();

   logic                    in_valid;
   logic                    in_ready;
   logic                    dp_reset;
   logic [TAPS*ACC_W-1:0]   dp_acc;
   logic                    out_valid;
   logic                    out_ready;
   logic [TAPS*OUT_W-1:0]   out_data;

   modport master (
      input  in_valid, dp_acc, out_ready,
      output in_ready, dp_reset, out_valid, out_data
   );

   modport slave (
      output in_valid, dp_acc, out_ready,
      input  in_ready, dp_reset, out_valid, out_data
   );

endinterface

// File: rtl/conv_seq_lane_fmt.sv
// rtl/conv_seq_lane_fmt.sv - one accumulator lane to integer pixel, truncating shift
// CONV_SEQ_SAT_EN defined: clamp to unsigned 8-bit; undefined: raw two's-complement integer part.
module conv_seq_lane_fmt
   import conv_pkg::*;
(
   input  logic [ACC_W-1:0] acc_i,
   output logic [OUT_W-1:0] pix_o
);

   logic [OUT_W-1:0]  int_part;
   logic              unused_frac;

   assign int_part    = acc_i[ACC_W-1:FRAC_W];
   assign unused_frac = ^acc_i[FRAC_W-1:0];

`ifdef CONV_SEQ_SAT_EN
   // Sign bit wins first so large negatives never compare as "above 255".
   always_comb begin
      pix_o = int_part;
      if (acc_i[ACC_W-1]) begin
         pix_o = SAT_MIN;
      end else if (int_part > SAT_MAX) begin
         pix_o = SAT_MAX;
      end
   end
`else
   assign pix_o = int_part;
`endif

endmodule

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - 3x3 convolution tile sequencer: beat/tile counting, result capture, handoff
// Output formatting depends on CONV_SEQ_SAT_EN (see conv_seq_lane_fmt).
module conv_seq_ctrl
   import conv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [TILE_W-1:0] tile_count,
   output logic              busy,
   output logic              done,
   output logic              err_underrun,
   conv_seq_ctrl_if.master   bus
);

   state_e                  state_q, state_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [TILE_W-1:0]       tiles_q, tiles_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    in_ready_q, in_ready_d;
   logic                    dp_reset_q, dp_reset_d;
   logic                    out_valid_q, out_valid_d;
   logic [TAPS*OUT_W-1:0]   out_data_q, out_data_d;
   logic [TAPS*OUT_W-1:0]   fmt_data;

   for (genvar g = 0; g < TAPS; g++) begin : g_lane
      conv_seq_lane_fmt u_fmt (
         .acc_i (bus.dp_acc[g*ACC_W +: ACC_W]),
         .pix_o (fmt_data[g*OUT_W +: OUT_W])
      );
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      tiles_d    = tiles_q;
      err_d      = err_q;
      done_d     = 1'b0;
      out_data_d = out_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (tile_count != '0) begin
                  tiles_d = tile_count;
                  err_d   = 1'b0;
                  state_d = ST_WAIT;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (bus.in_valid) begin
               beat_d  = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            // A gap mid-tile poisons the accumulators; restart the whole tile.
            if (bus.in_valid) begin
               if (beat_q == BEAT_W'(TAPS-1)) begin
                  state_d = ST_DRAIN;
               end else begin
                  beat_d  = beat_q + 1'b1;
               end
            end else begin
               err_d   = 1'b1;
               beat_d  = '0;
               state_d = ST_WAIT;
            end
         end
         ST_DRAIN: begin
            out_data_d = fmt_data;
            state_d    = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               tiles_d = tiles_q - 1'b1;
               if (tiles_q == TILE_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered copies of the next-state decode, so they align with state_q.
      busy_d      = (state_d != ST_IDLE);
      in_ready_d  = (state_d == ST_MAC);
      dp_reset_d  = !((state_d == ST_MAC) || (state_d == ST_DRAIN));
      out_valid_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         tiles_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         dp_reset_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         tiles_q     <= tiles_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         dp_reset_q  <= dp_reset_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign err_underrun  = err_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.dp_reset  = dp_reset_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

endmodule
